// File: rtl/alu_pkg.sv
// Shared ALU definitions: the alu_ctrl code set used by the decoder and the ALU,
// plus the multiply/divide state encoding and operation decode helpers.
package alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'b00000,
        ALU_SUB    = 5'b00001,
        ALU_SLL    = 5'b00010,
        ALU_SLT    = 5'b00011,
        ALU_SLTU   = 5'b00100,
        ALU_XOR    = 5'b00101,
        ALU_SRL    = 5'b00110,
        ALU_SRA    = 5'b00111,
        ALU_OR     = 5'b01000,
        ALU_AND    = 5'b01001,
        ALU_MUL    = 5'b01010,
        ALU_MULH   = 5'b01011,
        ALU_MULHSU = 5'b01100,
        ALU_MULHU  = 5'b01101,
        ALU_DIV    = 5'b01110,
        ALU_DIVU   = 5'b01111,
        ALU_REM    = 5'b10000,
        ALU_REMU   = 5'b10001
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    // Per-operation attributes the multiply/divide datapath needs.
    typedef struct packed {
        logic is_div;
        logic want_rem;
        logic want_hi;
        logic sign_a;
        logic sign_b;
    } muldiv_op_t;

    function automatic logic is_muldiv(input logic [4:0] ctrl);
        return (ctrl >= ALU_MUL) && (ctrl <= ALU_REMU);
    endfunction

    function automatic muldiv_op_t decode_muldiv(input logic [4:0] ctrl);
        muldiv_op_t d;
        d = '0;
        case (ctrl)
            ALU_MULH:   begin d.want_hi = 1'b1; d.sign_a = 1'b1; d.sign_b = 1'b1; end
            ALU_MULHSU: begin d.want_hi = 1'b1; d.sign_a = 1'b1; end
            ALU_MULHU:  begin d.want_hi = 1'b1; end
            ALU_DIV:    begin d.is_div = 1'b1; d.sign_a = 1'b1; d.sign_b = 1'b1; end
            ALU_DIVU:   begin d.is_div = 1'b1; end
            ALU_REM:    begin d.is_div = 1'b1; d.want_rem = 1'b1; d.sign_a = 1'b1; d.sign_b = 1'b1; end
            ALU_REMU:   begin d.is_div = 1'b1; d.want_rem = 1'b1; end
            default:    ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath: a shift-add multiply step and a
// restoring-division trial-subtract step, both on unsigned magnitudes.
module muldiv_step
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2*DATA_WIDTH-1:0] prod,
    input  logic [DATA_WIDTH-1:0]   mcand,
    input  logic [DATA_WIDTH:0]     rem,
    input  logic [DATA_WIDTH-1:0]   quot,
    input  logic [DATA_WIDTH-1:0]   divisor,
    output logic [2*DATA_WIDTH-1:0] prod_next,
    output logic [DATA_WIDTH:0]     rem_next,
    output logic [DATA_WIDTH-1:0]   quot_next
);

    localparam int W = DATA_WIDTH;

    logic [W:0]   hi_sum;
    logic [W+1:0] shifted;
    logic [W+1:0] diff;

    // NOTE: every variable written here gets a default first so no path leaves a latch.
    always_comb begin
        hi_sum    = '0;
        shifted   = '0;
        diff      = '0;
        prod_next = '0;
        rem_next  = '0;
        quot_next = '0;

        // Multiplier bits sit in the low half and are consumed LSB first.
        hi_sum    = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_next = {hi_sum, prod[W-1:1]};

        // The partial remainder is always below the divisor, so the top bit of shifted is 0
        // and diff's MSB is a clean borrow flag.
        shifted = {rem, quot[W-1]};
        diff    = shifted - {2'b00, divisor};
        if (!diff[W+1]) begin
            rem_next  = diff[W:0];
            quot_next = {quot[W-2:0], 1'b1};
        end else begin
            rem_next  = shifted[W:0];
            quot_next = {quot[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle on operand magnitudes,
// then a sign-fix cycle and a one-cycle done pulse. Division special cases finish early.
module muldiv_unit
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ALUCTR_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ALUCTR_WIDTH-1:0] alu_ctrl,
    input  logic [DATA_WIDTH-1:0]   op_a,
    input  logic [DATA_WIDTH-1:0]   op_b,
    input  logic                    flush,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   result
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CALC = CALC;
    localparam logic [1:0] ST_FIX  = FIX;
    localparam logic [1:0] ST_DONE = DONE;

    localparam logic [W-1:0]     MOST_NEG  = {1'b1, {(W-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic             op_div_q;
    logic             op_rem_q;
    logic             op_hi_q;
    logic             neg_a_q;
    logic             neg_b_q;
    logic [W-1:0]     mcand_q;
    logic [W-1:0]     divisor_q;
    logic [W-1:0]     quot_q;
    logic [W:0]       rem_q;
    logic [2*W-1:0]   prod_q;
    logic [W-1:0]     fixed_q;

    // Accept-time decode.
    muldiv_op_t op_in;
    logic       accept;
    logic       neg_a_in;
    logic       neg_b_in;
    logic [W-1:0] mag_a_in;
    logic [W-1:0] mag_b_in;
    logic       div_zero;
    logic       div_ovf;
    logic       special;
    logic [W-1:0] special_val;

    always_comb begin
        op_in    = decode_muldiv(alu_ctrl);
        accept   = start && (state == ST_IDLE) && !flush && is_muldiv(alu_ctrl);
        neg_a_in = op_in.sign_a && op_a[W-1];
        neg_b_in = op_in.sign_b && op_b[W-1];
        // Unary minus on W bits maps the most-negative value onto its own unsigned magnitude.
        mag_a_in = neg_a_in ? -op_a : op_a;
        mag_b_in = neg_b_in ? -op_b : op_b;
        div_zero = op_in.is_div && (op_b == '0);
        div_ovf  = op_in.is_div && op_in.sign_a && (op_a == MOST_NEG) && (op_b == '1);
        special  = div_zero || div_ovf;
        if (div_zero) begin
            special_val = op_in.want_rem ? op_a : '1;
        end else begin
            special_val = op_in.want_rem ? '0 : op_a;
        end
    end

    logic [2*W-1:0] prod_next;
    logic [W:0]     rem_next;
    logic [W-1:0]   quot_next;

    muldiv_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .prod     (prod_q),
        .mcand    (mcand_q),
        .rem      (rem_q),
        .quot     (quot_q),
        .divisor  (divisor_q),
        .prod_next(prod_next),
        .rem_next (rem_next),
        .quot_next(quot_next)
    );

    // Sign fix and result select.
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   quot_s;
    logic [W-1:0]   rem_s;
    logic [W-1:0]   fix_val;

    always_comb begin
        prod_s = (neg_a_q ^ neg_b_q) ? -prod_q : prod_q;
        quot_s = (neg_a_q ^ neg_b_q) ? -quot_q : quot_q;
        rem_s  = neg_a_q ? -rem_q[W-1:0] : rem_q[W-1:0];
        if (op_div_q) begin
            fix_val = op_rem_q ? rem_s : quot_s;
        end else begin
            fix_val = op_hi_q ? prod_s[2*W-1:W] : prod_s[W-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            op_div_q  <= 1'b0;
            op_rem_q  <= 1'b0;
            op_hi_q   <= 1'b0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            mcand_q   <= '0;
            divisor_q <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            prod_q    <= '0;
            fixed_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_div_q  <= op_in.is_div;
                        op_rem_q  <= op_in.want_rem;
                        op_hi_q   <= op_in.want_hi;
                        neg_a_q   <= neg_a_in;
                        neg_b_q   <= neg_b_in;
                        mcand_q   <= mag_a_in;
                        divisor_q <= mag_b_in;
                        quot_q    <= mag_a_in;
                        rem_q     <= '0;
                        prod_q    <= {{W{1'b0}}, mag_b_in};
                        count     <= '0;
                        busy      <= 1'b1;
                        if (special) begin
                            fixed_q <= special_val;
                            state   <= ST_DONE;
                        end else begin
                            state   <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        prod_q <= prod_next;
                        rem_q  <= rem_next;
                        quot_q <= quot_next;
                        count  <= count + CNT_W'(1);
                        if (count == LAST_STEP) begin
                            state <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    if (flush) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        fixed_q <= fix_val;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Flush is ignored here: the operation has already committed.
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    result <= fixed_q;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M corner cases, flush/reset/ignore
// behaviour, and randomized operations against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int W = 32;

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_MUL    = 5'b01010;
    localparam logic [4:0] OP_MULH   = 5'b01011;
    localparam logic [4:0] OP_MULHSU = 5'b01100;
    localparam logic [4:0] OP_MULHU  = 5'b01101;
    localparam logic [4:0] OP_DIV    = 5'b01110;
    localparam logic [4:0] OP_DIVU   = 5'b01111;
    localparam logic [4:0] OP_REM    = 5'b10000;
    localparam logic [4:0] OP_REMU   = 5'b10001;

    localparam logic [W-1:0] MOST_NEG = 32'h8000_0000;

    logic         clk;
    logic         rst;
    logic         start;
    logic [4:0]   alu_ctrl;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int n_tests;
    int n_fail;
    logic [W-1:0] last_res;

    muldiv_unit #(
        .DATA_WIDTH  (W),
        .ALUCTR_WIDTH(5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .alu_ctrl(alu_ctrl),
        .op_a    (op_a),
        .op_b    (op_b),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: RV32M semantics written with plain integer arithmetic.
    function automatic logic [W-1:0] model(input logic [4:0] ctrl, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        int          sa;
        int          sb;
        longint      ps;
        logic [63:0] pu;
        logic [W-1:0] r;
        sa = a;
        sb = b;
        r  = '0;
        case (ctrl)
            OP_MUL: begin
                pu = {32'h0, a} * {32'h0, b};
                r  = pu[31:0];
            end
            OP_MULH: begin
                ps = longint'(sa) * longint'(sb);
                pu = ps;
                r  = pu[63:32];
            end
            OP_MULHSU: begin
                ps = longint'(sa) * longint'({32'h0, b});
                pu = ps;
                r  = pu[63:32];
            end
            OP_MULHU: begin
                pu = {32'h0, a} * {32'h0, b};
                r  = pu[63:32];
            end
            OP_DIV: begin
                if (b == 0)                          r = '1;
                else if (a == MOST_NEG && b == '1)   r = a;
                else                                 r = sa / sb;
            end
            OP_REM: begin
                if (b == 0)                          r = a;
                else if (a == MOST_NEG && b == '1)   r = '0;
                else                                 r = sa % sb;
            end
            OP_DIVU: r = (b == 0) ? '1 : a / b;
            OP_REMU: r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int exp_latency(input logic [4:0] ctrl, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
        logic is_div;
        logic signed_div;
        is_div     = (ctrl == OP_DIV) || (ctrl == OP_DIVU) || (ctrl == OP_REM) || (ctrl == OP_REMU);
        signed_div = (ctrl == OP_DIV) || (ctrl == OP_REM);
        if (is_div && (b == 0)) return 1;
        if (signed_div && a == MOST_NEG && b == '1) return 1;
        return W + 2;
    endfunction

    // Drives a one-cycle start; returns just after the sampling edge.
    task automatic issue_start(input logic [4:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start    = 1'b1;
        alu_ctrl = ctrl;
        op_a     = a;
        op_b     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until done, with a bound; checks latency, result, pulse width and busy.
    task automatic wait_done(input string tag, input int lat, input logic [W-1:0] exp_res);
        int n;
        int busy_gaps;
        int both_high;
        n         = 0;
        busy_gaps = 0;
        both_high = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (done && busy) both_high++;
            if (done) break;
            if (!busy) busy_gaps++;
        end
        check({tag, "_latency"}, 64'(n), 64'(lat));
        check({tag, "_result"}, {32'h0, result}, {32'h0, exp_res});
        check({tag, "_busy_hold"}, 64'(busy_gaps), 64'd0);
        check({tag, "_busy_done_overlap"}, 64'(both_high), 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_width"}, {63'h0, done}, 64'd0);
        last_res = exp_res;
    endtask

    task automatic run_op(input string tag, input logic [4:0] ctrl, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        issue_start(ctrl, a, b);
        wait_done(tag, exp_latency(ctrl, a, b), model(ctrl, a, b));
    endtask

    // Watches for any done/busy activity over a number of cycles.
    task automatic quiet_window(input int cycles, output int done_seen, output int busy_seen);
        done_seen = 0;
        busy_seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
            if (busy) busy_seen++;
        end
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 9))
            0:       return '0;
            1:       return MOST_NEG;
            2:       return '1;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    logic [4:0] op_table [8] = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                                 OP_DIV, OP_DIVU, OP_REM, OP_REMU};

    initial begin
        int d_seen;
        int b_seen;
        logic [4:0]   rc;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        n_tests  = 0;
        n_fail   = 0;
        last_res = '0;
        rst      = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        alu_ctrl = '0;
        op_a     = '0;
        op_b     = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {63'h0, busy}, 64'd0);
        check("reset_done", {63'h0, done}, 64'd0);
        check("reset_result", {32'h0, result}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed arithmetic corners, expected values written out by hand.
        issue_start(OP_MUL, 32'd7, 32'hFFFF_FFFD);
        wait_done("mul_7_m3", 34, 32'hFFFF_FFEB);
        issue_start(OP_MULH, MOST_NEG, MOST_NEG);
        wait_done("mulh_min_min", 34, 32'h4000_0000);
        issue_start(OP_MULHU, '1, '1);
        wait_done("mulhu_ones", 34, 32'hFFFF_FFFE);
        issue_start(OP_MULHSU, '1, '1);
        wait_done("mulhsu_ones", 34, 32'hFFFF_FFFF);
        issue_start(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_m7_2", 34, 32'hFFFF_FFFD);
        issue_start(OP_REM, 32'hFFFF_FFF9, 32'd2);
        wait_done("rem_m7_2", 34, 32'hFFFF_FFFF);
        issue_start(OP_DIVU, 32'd100, 32'd7);
        wait_done("divu_100_7", 34, 32'd14);
        issue_start(OP_REMU, 32'd100, 32'd7);
        wait_done("remu_100_7", 34, 32'd2);
        issue_start(OP_DIV, 32'd5, 32'd0);
        wait_done("div_by_zero", 1, 32'hFFFF_FFFF);
        issue_start(OP_REM, 32'd5, 32'd0);
        wait_done("rem_by_zero", 1, 32'd5);
        issue_start(OP_DIV, MOST_NEG, '1);
        wait_done("div_overflow", 1, MOST_NEG);
        issue_start(OP_REM, MOST_NEG, '1);
        wait_done("rem_overflow", 1, 32'd0);
        issue_start(OP_DIVU, MOST_NEG, '1);
        wait_done("divu_min_ones", 34, 32'd0);
        issue_start(OP_DIV, MOST_NEG, 32'd1);
        wait_done("div_min_1", 34, MOST_NEG);

        // Flush during CALC: busy drops, no done, result unchanged.
        issue_start(OP_MUL, 32'd1234, 32'd5678);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush_busy_low", {63'h0, busy}, 64'd0);
        @(negedge clk);
        flush = 1'b0;
        quiet_window(40, d_seen, b_seen);
        check("flush_no_done", 64'(d_seen), 64'd0);
        check("flush_result_kept", {32'h0, result}, {32'h0, last_res});

        // Start together with flush in IDLE is not accepted.
        @(negedge clk);
        flush    = 1'b1;
        start    = 1'b1;
        alu_ctrl = OP_DIVU;
        op_a     = 32'd9;
        op_b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        quiet_window(40, d_seen, b_seen);
        check("flush_start_no_busy", 64'(b_seen), 64'd0);
        check("flush_start_no_done", 64'(d_seen), 64'd0);

        // Non-muldiv code is ignored.
        issue_start(OP_ADD, 32'd3, 32'd4);
        quiet_window(40, d_seen, b_seen);
        check("add_no_busy", 64'(b_seen), 64'd0);
        check("add_no_done", 64'(d_seen), 64'd0);
        check("add_result_kept", {32'h0, result}, {32'h0, last_res});

        // Second start while busy is ignored; first operation completes unchanged.
        issue_start(OP_DIVU, 32'd1000, 32'd33);
        check("busy_after_accept", {63'h0, busy}, 64'd1);
        repeat (2) @(posedge clk);
        issue_start(OP_MUL, 32'd3, 32'd3);
        wait_done("start_while_busy", 31, 32'd30);

        // Asynchronous reset mid-CALC clears outputs immediately.
        issue_start(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_busy", {63'h0, busy}, 64'd0);
        check("rst_mid_done", {63'h0, done}, 64'd0);
        check("rst_mid_result", {32'h0, result}, 64'd0);
        @(negedge clk);
        rst      = 1'b0;
        last_res = '0;
        run_op("after_reset", OP_REM, 32'hFFFF_FF9C, 32'd7);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            rc = op_table[$urandom_range(0, 7)];
            ra = rand_operand();
            rb = rand_operand();
            run_op($sformatf("rand%0d_op%0h_%0h_%0h", i, rc, ra, rb), rc, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
